logic_unit_arbiter: RTL and testbench

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/logic_unit_arbiter.sv | 104 ++++++++++
 tb/tb_logic_unit_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of a shared bitwise logic unit.
// One operation is held in a response register until the consumer takes it.
module logic_unit_arbiter #(
  parameter int WIDTH = 8,
  localparam int NREQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [3*NREQ-1:0]  req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [1:0]         rsp_id,
  output logic               rsp_err,
  output logic [15:0]        op_count
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       idx;
  logic [1:0]       win;
  logic             found;
  logic [NREQ-1:0]  grant;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res;
  logic             err;

  // First valid requester at or after ptr, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign grant = found ? (4'b0001 << win) : '0;
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;

  // Only the winner's lanes reach the logic unit.
  always_comb begin
    op  = req_op[3*int'(win) +: 3];
    a   = req_a[WIDTH*int'(win) +: WIDTH];
    b   = req_b[WIDTH*int'(win) +: WIDTH];
    res = '0;
    err = 1'b0;
    unique case (op)
      3'd0:    res = a & b;
      3'd1:    res = a | b;
      3'd2:    res = a ^ b;
      3'd3:    res = ~(a & b);
      3'd4:    res = ~(a | b);
      3'd5:    res = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            ptr       <= win + 2'd1;
            rsp_data  <= res;
            rsp_id    <= win;
            rsp_err   <= err;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter.
// Expected responses are queued at grant time and popped on rsp_valid.
module tb_logic_unit_arbiter;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] id;
    logic       err;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [11:0] req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_err;
  logic [15:0] op_count;

  logic [2:0] op_of [4];
  logic [7:0] a_of [4];
  logic [7:0] b_of [4];

  resp_t      exp_q [$];
  logic [1:0] mptr;
  int         mcount;
  int         checks;
  int         failures;

  logic_unit_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_op = '0;
    req_a  = '0;
    req_b  = '0;
    for (int i = 0; i < 4; i++) begin
      req_op[3*i +: 3] = op_of[i];
      req_a[8*i +: 8]  = a_of[i];
      req_b[8*i +: 8]  = b_of[i];
    end
  end

  function automatic logic [8:0] model_alu(
    input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, a ^ b};
      3'd3: return {1'b0, ~(a & b)};
      3'd4: return {1'b0, ~(a | b)};
      3'd5: return {1'b0, ~(a ^ b)};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  task automatic set_req(input int i, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    op_of[i] = op;
    a_of[i]  = a;
    b_of[i]  = b;
  endtask

  // Drives req_valid; if the model grants, queues the expected response.
  task automatic present(input logic [3:0] v, output logic [3:0] g);
    int w;
    resp_t e;
    logic [8:0] r;
    req_valid = v;
    g = '0;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (int'(mptr) + k) % 4;
      if (w < 0 && v[j]) w = j;
    end
    if (w >= 0) begin
      g = 4'b0001 << w;
      r = model_alu(op_of[w], a_of[w], b_of[w]);
      e.data = r[7:0];
      e.id   = w[1:0];
      e.err  = r[8];
      exp_q.push_back(e);
      mptr = w[1:0] + 2'd1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 3'd0, 8'hFF, 8'hFF);
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (op_count !== 16'd0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n = 1'b1;
    mptr = '0;
    mcount = 0;
  endtask

  task automatic test_single;
    logic [3:0] g;
    resp_t e;
    set_req(2, 3'd0, 8'hF0, 8'h3C);
    present(4'b0100, g);
    #1;
    checks++; if (req_ready !== 4'b0100 || g !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_ready_resp got=%b exp=0000", req_ready); end
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    e = exp_q.pop_front();
    checks++; if (rsp_data !== 8'h30 || rsp_data !== e.data) begin failures++; $display("FAIL single_data got=%h exp=%h", rsp_data, e.data); end
    checks++; if (rsp_id !== 2'd2 || rsp_err !== 1'b0) begin failures++; $display("FAIL single_id_err got=%0d/%b exp=2/0", rsp_id, rsp_err); end
    rsp_ready = 1'b1;
    @(negedge clk);
    mcount++;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || op_count !== 16'(mcount)) begin failures++; $display("FAIL single_done got=%b/%0d exp=0/%0d", rsp_valid, op_count, mcount); end
  endtask

  task automatic test_opcodes;
    logic [3:0] g;
    logic [7:0] lit [6];
    resp_t e;
    lit = '{8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99};
    for (int op = 0; op < 6; op++) begin
      set_req(0, 3'(op), 8'hAA, 8'hCC);
      present(4'b0001, g);
      #1;
      checks++; if (req_ready !== g) begin failures++; $display("FAIL op%0d_grant got=%b exp=%b", op, req_ready, g); end
      @(negedge clk);
      req_valid = '0;
      if (exp_q.size() == 0) begin
        checks++; failures++; $display("FAIL op%0d_queue got=empty exp=entry", op);
      end else begin
        e = exp_q.pop_front();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_data !== lit[op] || rsp_err !== 1'b0) begin
          failures++; $display("FAIL op%0d_data got=%b/%h exp=1/%h", op, rsp_valid, rsp_data, lit[op]);
        end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      mcount++;
      rsp_ready = 1'b0;
    end
    checks++; if (op_count !== 16'(mcount)) begin failures++; $display("FAIL op_count got=%0d exp=%0d", op_count, mcount); end
  endtask

  task automatic test_backpressure;
    logic [3:0] g;
    resp_t e;
    set_req(1, 3'd2, 8'h5A, 8'h0F);
    present(4'b0010, g);
    #1;
    checks++; if (req_ready !== g) begin failures++; $display("FAIL bp_grant got=%b exp=%b", req_ready, g); end
    @(negedge clk);
    e = exp_q.pop_front();
    set_req(1, 3'd1, 8'h00, 8'h00);
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_id !== e.id || req_ready !== 4'b0000) begin
        failures++; $display("FAIL bp_hold%0d got=%b/%h/%0d/%b exp=1/%h/%0d/0000", c, rsp_valid, rsp_data, rsp_id, req_ready, e.data, e.id);
      end
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    mcount++;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || op_count !== 16'(mcount)) begin failures++; $display("FAIL bp_release got=%b/%0d exp=0/%0d", rsp_valid, op_count, mcount); end
  endtask

  task automatic test_illegal;
    logic [3:0] g;
    resp_t e;
    set_req(3, 3'd7, 8'hFF, 8'hFF);
    present(4'b1000, g);
    @(negedge clk);
    req_valid = '0;
    e = exp_q.pop_front();
    checks++; if (rsp_err !== 1'b1 || rsp_data !== 8'h00 || rsp_id !== 2'd3 || e.err !== 1'b1) begin
      failures++; $display("FAIL illegal got=%b/%h/%0d exp=1/00/3", rsp_err, rsp_data, rsp_id);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    mcount++;
    rsp_ready = 1'b0;
    set_req(3, 3'd1, 8'h12, 8'h34);
    present(4'b1000, g);
    @(negedge clk);
    req_valid = '0;
    e = exp_q.pop_front();
    checks++; if (rsp_err !== 1'b0 || rsp_data !== e.data || rsp_data !== 8'h36) begin
      failures++; $display("FAIL legal_after got=%b/%h exp=0/36", rsp_err, rsp_data);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    mcount++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [3:0] g;
    resp_t e;
    set_req(2, 3'd2, 8'h0F, 8'hF0);
    present(4'b0100, g);
    @(negedge clk);
    req_valid = '0;
    e = exp_q.pop_front();
    checks++; if (rsp_valid !== 1'b1 || op_count === 16'd0) begin failures++; $display("FAIL mid_pre got=%b/%0d exp=1/nonzero", rsp_valid, op_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || op_count !== 16'd0) begin failures++; $display("FAIL mid_async got=%b/%0d exp=0/0", rsp_valid, op_count); end
    mptr = '0;
    mcount = 0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1, 3'd0, 8'h3C, 8'h0F);
    set_req(3, 3'd1, 8'h01, 8'h02);
    present(4'b1010, g);
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL mid_first_grant got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    e = exp_q.pop_front();
    checks++; if (rsp_id !== 2'd1 || rsp_data !== e.data) begin failures++; $display("FAIL mid_first_rsp got=%0d/%h exp=1/%h", rsp_id, rsp_data, e.data); end
    rsp_ready = 1'b1;
    @(negedge clk);
    mcount++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_fairness;
    logic [3:0] g;
    resp_t e;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mptr = '0;
    mcount = 0;
    for (int i = 0; i < 4; i++) set_req(i, 3'(i), 8'(8'h21 * i + 8'h13), 8'(8'h35 + i));
    rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      present(4'b1111, g);
      #1;
      checks++; if (req_ready !== g || $countones(req_ready) > 1) begin failures++; $display("FAIL fair%0d_grant got=%b exp=%b", n, req_ready, g); end
      @(negedge clk);
      checks++; if ($countones(req_ready) > 1) begin failures++; $display("FAIL fair%0d_onehot got=%b exp=at_most_one", n, req_ready); end
      if (exp_q.size() == 0) begin
        checks++; failures++; $display("FAIL fair%0d_queue got=empty exp=entry", n);
      end else begin
        e = exp_q.pop_front();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(n % 4) || rsp_id !== e.id || rsp_data !== e.data) begin
          failures++; $display("FAIL fair%0d_rsp got=%b/%0d/%h exp=1/%0d/%h", n, rsp_valid, rsp_id, rsp_data, n % 4, e.data);
        end
      end
      @(negedge clk);
      mcount++;
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    checks++; if (op_count !== 16'(mcount)) begin failures++; $display("FAIL fair_count got=%0d exp=%0d", op_count, mcount); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    mptr = '0;
    mcount = 0;
    req_valid = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_opcodes();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_fairness();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL queue_drain got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
